regfile_wb_scheduler: RTL



---
 rtl/regfile_ctrl_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 35 +++
 rtl/regfile_wb_scheduler.sv | 101 ++++++++++
 3 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
// Imported by the arbiter and the top-level scheduler.
package regfile_ctrl_pkg;

   localparam int NREG = 64;
   localparam int AW   = 6;
   localparam int DW   = 32;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_MEM = 1'b1
   } req_e;

   typedef struct packed {
      logic [AW-1:0] rd;
      logic [DW-1:0] val;
   } wb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester always wins, a contended
// cycle goes to the pointer, and the pointer flips away from every winner.
module rr_arbiter2
   import regfile_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   req_e ptr;

   always_comb begin
      gnt = 2'b00;
      if (!rst) begin
         if (req[0] && req[1]) begin
            gnt = (ptr == REQ_ALU) ? 2'b01 : 2'b10;
         end else begin
            gnt = req;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= REQ_ALU;
      end else if (gnt[0]) begin
         ptr <= REQ_MEM;
      end else if (gnt[1]) begin
         ptr <= REQ_ALU;
      end
   end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler for the single-write-port register file: arbitrates the
// ALU and load paths, registers the write, and stalls issue on pending registers.
module regfile_wb_scheduler
   import regfile_ctrl_pkg::*;
(
   input  logic          in_clk,
   input  logic          in_rst,
   input  logic          in_issue_valid,
   input  logic          in_issue_wr,
   input  logic [AW-1:0] in_issue_rs,
   input  logic [AW-1:0] in_issue_rt,
   input  logic [AW-1:0] in_issue_rd,
   output logic          out_issue_stall,
   input  logic          in_alu_valid,
   input  logic [AW-1:0] in_alu_rd,
   input  logic [DW-1:0] in_alu_val,
   output logic          out_alu_ready,
   input  logic          in_mem_valid,
   input  logic [AW-1:0] in_mem_rd,
   input  logic [DW-1:0] in_mem_val,
   output logic          out_mem_ready,
   output logic          out_ctrl_regwrt,
   output logic [AW-1:0] out_rd,
   output logic [DW-1:0] out_rdval,
   output logic          out_wb_err
);

   logic [NREG-1:0] pending;
   logic [NREG-1:0] pending_vis;
   logic [NREG-1:0] pending_nxt;
   logic [1:0]      gnt;
   logic            hs;
   logic            accept;
   wb_req_t         alu_req;
   wb_req_t         mem_req;
   wb_req_t         win_req;

   logic            wb_wrt_p1;
   logic [AW-1:0]   wb_rd_p1;
   logic [DW-1:0]   wb_val_p1;
   logic            wb_err;

   rr_arbiter2 u_arb (
      .clk (in_clk),
      .rst (in_rst),
      .req ({in_mem_valid, in_alu_valid}),
      .gnt (gnt)
   );

   assign alu_req       = '{rd: in_alu_rd, val: in_alu_val};
   assign mem_req       = '{rd: in_mem_rd, val: in_mem_val};
   assign out_alu_ready = gnt[0];
   assign out_mem_ready = gnt[1];
   assign hs            = gnt[0] | gnt[1];
   assign win_req       = gnt[1] ? mem_req : alu_req;

   // During reset the scoreboard is treated as already cleared.
   assign pending_vis     = in_rst ? '0 : pending;
   assign out_issue_stall = in_issue_valid &
                            (pending_vis[in_issue_rs] | pending_vis[in_issue_rt] |
                             (in_issue_wr & pending_vis[in_issue_rd]));
   assign accept          = in_issue_valid & ~out_issue_stall;

   // Set is applied after clear so it wins on a same-bit collision.
   always_comb begin
      pending_nxt = pending;
      if (hs) begin
         pending_nxt[win_req.rd] = 1'b0;
      end
      if (accept && in_issue_wr) begin
         pending_nxt[in_issue_rd] = 1'b1;
      end
   end

   // Stage p1: registered register-file write port and scoreboard.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         pending   <= '0;
         wb_wrt_p1 <= 1'b0;
         wb_rd_p1  <= '0;
         wb_val_p1 <= '0;
         wb_err    <= 1'b0;
      end else begin
         pending   <= pending_nxt;
         wb_wrt_p1 <= hs;
         if (hs) begin
            wb_rd_p1  <= win_req.rd;
            wb_val_p1 <= win_req.val;
            if (!pending[win_req.rd]) begin
               wb_err <= 1'b1;
            end
         end
      end
   end

   assign out_ctrl_regwrt = wb_wrt_p1;
   assign out_rd          = wb_rd_p1;
   assign out_rdval       = wb_val_p1;
   assign out_wb_err      = wb_err;

endmodule
